blake_g_inverse: RTL and testbench
==================================

# blake_g_inverse

Pipelined inverse of the BLAKE-256 G mixing function. It takes the four post-G state words and the same two pre-combined message/constant words the forward G consumed, and recovers the four pre-G state words. It sits beside the forward G pipeline in the miner's verification and debug path, where it un-mixes captured round state for self-check and for bit-exact golden comparison. It is a fully pipelined datapath with a valid shift chain and a global clock enable that stalls the pipe.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all pipeline state
- ce  in  1  clock enable; low freezes every register, including valids
- in_valid  in  1  input word set is valid this cycle (sampled when ce=1)
- a, b, c, d  in  32 each  post-G state words
- msg_i  in  32  first message word used by forward G (m[σ(2i)]^c[σ(2i+1)] already folded)
- msg_ip  in  32  second message word (m[σ(2i+1)]^c[σ(2i)] already folded)
- out_valid  out  1  recovered words valid
- a_out, b_out, c_out, d_out  out  32 each  pre-G state words

## Operation
- All arithmetic is modulo 2^32. rotl(x,n) is a left rotate and inverts the forward right rotate.
- Stage 1:
  - b1 = rotl(b,7) ^ c
  - c1 = c − d
  - d1 = rotl(d,8) ^ a
  - a, msg_i and msg_ip are carried forward.
- Stage 2:
  - a2 = a1 − b1 − msg_ip
  - b2 = rotl(b1,12) ^ c1
  - c1, d1 and msg_i are carried forward.
- Stage 3:
  - c3 = c2 − d2
  - d3 = rotl(d2,16) ^ a2
  - a2, b2 and msg_i are carried forward.
- Stage 4:
  - a4 = a3 − b3 − msg_i
  - b3, c3 and d3 are carried forward.
- Stage 4 registers drive the outputs directly: a_out=a4, b_out=b3, c_out=c3, d_out=d3.
- Each stage computes with a single ternary add/subtract at most (Spartan-6 LUT6 ternary adder); no carry-save trees.
- The valid bit moves through a 4-deep shift chain alongside the data.
- Data registers always load when ce=1, whether or not valid is set. Downstream logic qualifies data only by out_valid.

## Timing
- Latency is 4 ce-enabled cycles from in_valid sampled high to out_valid high with the matching result.
- Throughput is one word set per enabled cycle; back-to-back valids are supported with no bubbles.
- ce=0 holds every data and valid register; outputs stay stable; the inputs in that cycle are ignored.
- reset asserted (any time, asynchronous):
  - out_valid=0 and all four outputs = 0x00000000 immediately.
  - All internal valid bits are cleared, so in-flight words are discarded.
- The first valid output after reset release appears 4 enabled cycles after the first sampled in_valid.
- Simultaneous reset and ce/in_valid: reset wins.

## Configuration
- BLAKE_GINV_REGOUT_EN defined:
  - Adds a fifth output register stage: a_out..d_out and out_valid are re-registered under the same ce and reset.
  - Latency becomes 5; throughput is unchanged.
- Undefined: latency is 4 and the outputs come directly from the stage 4 registers.

## Test plan
- Reset: hold reset for 3 cycles with random inputs -> out_valid=0 and all outputs 0 throughout; the first valid output comes 4 cycles after the first in_valid following release.
- Single vector: a=0x00000001, b=c=d=0, msg_i=msg_ip=0 -> after 4 cycles a_out=0x00000001, b_out=0, c_out=0xFFFFFFFF, d_out=0x00010001.
- Message path: a=b=c=d=0, msg_i=5, msg_ip=3 -> a_out=0xFFFFFFF8, b_out=0, c_out=0, d_out=0xFFFFFFFD.
- Round trip: 1000 random vectors streamed back-to-back through the reference forward G model, then into this block -> every output equals the original a,b,c,d, in order, with no gaps.
- Stall: drop ce for 3 cycles while 4 words are in flight -> outputs and out_valid are frozen; no word is lost or duplicated; the order is preserved.
- Mid-operation reset: assert reset while 3 words are in flight -> none of those words ever produces out_valid; a fresh word after release returns correctly.

Source files
------------

// File: rtl/blake_g_inverse.sv
// Pipelined inverse of the BLAKE-256 G mixing function: recovers pre-G state words in 4 stages.
// Define BLAKE_GINV_REGOUT_EN to add a fifth output register stage (latency 5).
module blake_g_inverse (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] msg_i,
    input  logic [31:0] msg_ip,
    output logic        out_valid,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    logic        v1_r, v2_r, v3_r, v4_r;
    logic [31:0] a1_r, b1_r, c1_r, d1_r, mi1_r, mip1_r;
    logic [31:0] a2_r, b2_r, c2_r, d2_r, mi2_r;
    logic [31:0] a3_r, b3_r, c3_r, d3_r, mi3_r;
    logic [31:0] a4_r, b4_r, c4_r, d4_r;

    // Stage 1: undo the final b rotate, c add and d rotate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r   <= 1'b0;
            a1_r   <= 32'h0;
            b1_r   <= 32'h0;
            c1_r   <= 32'h0;
            d1_r   <= 32'h0;
            mi1_r  <= 32'h0;
            mip1_r <= 32'h0;
        end else if (ce) begin
            v1_r   <= in_valid;
            a1_r   <= a;
            b1_r   <= rotl(b, 7) ^ c;
            c1_r   <= c - d;
            d1_r   <= rotl(d, 8) ^ a;
            mi1_r  <= msg_i;
            mip1_r <= msg_ip;
        end else begin
            v1_r <= v1_r;
        end
    end

    // Stage 2: undo the second a add (uses the second message word) and the b rotate by 12
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_r  <= 1'b0;
            a2_r  <= 32'h0;
            b2_r  <= 32'h0;
            c2_r  <= 32'h0;
            d2_r  <= 32'h0;
            mi2_r <= 32'h0;
        end else if (ce) begin
            v2_r  <= v1_r;
            a2_r  <= a1_r - b1_r - mip1_r;
            b2_r  <= rotl(b1_r, 12) ^ c1_r;
            c2_r  <= c1_r;
            d2_r  <= d1_r;
            mi2_r <= mi1_r;
        end else begin
            v2_r <= v2_r;
        end
    end

    // Stage 3: undo the first c add and the d rotate by 16
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v3_r  <= 1'b0;
            a3_r  <= 32'h0;
            b3_r  <= 32'h0;
            c3_r  <= 32'h0;
            d3_r  <= 32'h0;
            mi3_r <= 32'h0;
        end else if (ce) begin
            v3_r  <= v2_r;
            a3_r  <= a2_r;
            b3_r  <= b2_r;
            c3_r  <= c2_r - d2_r;
            d3_r  <= rotl(d2_r, 16) ^ a2_r;
            mi3_r <= mi2_r;
        end else begin
            v3_r <= v3_r;
        end
    end

    // Stage 4: undo the first a add (uses the first message word)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v4_r <= 1'b0;
            a4_r <= 32'h0;
            b4_r <= 32'h0;
            c4_r <= 32'h0;
            d4_r <= 32'h0;
        end else if (ce) begin
            v4_r <= v3_r;
            a4_r <= a3_r - b3_r - mi3_r;
            b4_r <= b3_r;
            c4_r <= c3_r;
            d4_r <= d3_r;
        end else begin
            v4_r <= v4_r;
        end
    end

`ifdef BLAKE_GINV_REGOUT_EN
    logic        v5_r;
    logic [31:0] a5_r, b5_r, c5_r, d5_r;

    // Optional output retiming stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v5_r <= 1'b0;
            a5_r <= 32'h0;
            b5_r <= 32'h0;
            c5_r <= 32'h0;
            d5_r <= 32'h0;
        end else if (ce) begin
            v5_r <= v4_r;
            a5_r <= a4_r;
            b5_r <= b4_r;
            c5_r <= c4_r;
            d5_r <= d4_r;
        end else begin
            v5_r <= v5_r;
        end
    end

    assign out_valid = v5_r;
    assign a_out     = a5_r;
    assign b_out     = b5_r;
    assign c_out     = c5_r;
    assign d_out     = d5_r;
`else
    assign out_valid = v4_r;
    assign a_out     = a4_r;
    assign b_out     = b4_r;
    assign c_out     = c4_r;
    assign d_out     = d4_r;
`endif

endmodule

// File: tb/tb_blake_g_inverse.sv
// Directed self-checking bench for blake_g_inverse; a forward G model feeds the round-trip and stall tests.
module tb_blake_g_inverse;

`ifdef BLAKE_GINV_REGOUT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0, c = 32'h0, d = 32'h0;
    logic [31:0] msg_i = 32'h0, msg_ip = 32'h0;
    logic        out_valid;
    logic [31:0] a_out, b_out, c_out, d_out;

    int checks = 0;
    int passes = 0;

    // Expected-output pipe: valid bit and expected {a,b,c,d} per enabled cycle
    logic         mv [0:4];
    logic [127:0] md [0:4];

    blake_g_inverse dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .msg_i(msg_i), .msg_ip(msg_ip),
        .out_valid(out_valid), .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference forward BLAKE-256 G
    function automatic logic [127:0] g_fwd(input logic [31:0] ia, ib, ic, id, imi, imip);
        logic [31:0] ta, tb, tc, td;
        ta = ia + ib + imi;
        td = rotr(id ^ ta, 16);
        tc = ic + td;
        tb = rotr(ib ^ tc, 12);
        ta = ta + tb + imip;
        td = rotr(td ^ ta, 8);
        tc = tc + td;
        tb = rotr(tb ^ tc, 7);
        return {ta, tb, tc, td};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 5; k++) begin
            mv[k] = 1'b0;
            md[k] = 128'h0;
        end
    endtask

    task automatic cyc(input logic v, input logic e, input logic [127:0] post,
                       input logic [31:0] imi, input logic [31:0] imip, input logic [127:0] expd);
        in_valid = v;
        ce       = e;
        {a, b, c, d} = post;
        msg_i    = imi;
        msg_ip   = imip;
        @(posedge clk);
        if (!reset && e) begin
            for (int k = LAT - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            mv[0] = v;
            md[0] = expd;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_model();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, $urandom(), $urandom(), 128'h0);
            checks++;
            if (out_valid !== 1'b0 || {a_out, b_out, c_out, d_out} !== 128'h0)
                $display("FAIL reset_hold: valid=%0b data=%h, want valid=0 data=0", out_valid, {a_out, b_out, c_out, d_out});
            else passes++;
        end
        reset = 1'b0;
        cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
        cyc(1'b1, 1'b1, {32'h1, 32'h0, 32'h0, 32'h0}, 32'h0, 32'h0,
            {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00010001});
        for (int j = 1; j <= LAT; j++) begin
            checks++;
            if (out_valid !== mv[LAT-1] || (mv[LAT-1] && {a_out, b_out, c_out, d_out} !== md[LAT-1]))
                $display("FAIL reset_first_out cyc%0d: valid=%0b data=%h, want valid=%0b data=%h",
                         j, out_valid, {a_out, b_out, c_out, d_out}, mv[LAT-1], md[LAT-1]);
            else passes++;
            if (j < LAT) cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
        end
    endtask

    task automatic test_vectors();
        cyc(1'b1, 1'b1, {32'h1, 32'h0, 32'h0, 32'h0}, 32'h0, 32'h0,
            {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00010001});
        cyc(1'b1, 1'b1, 128'h0, 32'h5, 32'h3,
            {32'hFFFFFFF8, 32'h00000000, 32'h00000000, 32'hFFFFFFFD});
        cyc(1'b1, 1'b1, {32'h0, 32'h1, 32'h0, 32'h0}, 32'h0, 32'h0,
            {32'hFFF7FF80, 32'h00080000, 32'h00000000, 32'hFFFFFF80});
        cyc(1'b1, 1'b1, {32'h0, 32'h0, 32'h1, 32'h0}, 32'h0, 32'h0,
            {32'hFFFFEFFE, 32'h00001001, 32'h00000001, 32'hFFFFFFFF});
        for (int j = 0; j < LAT + 1; j++) begin
            checks++;
            if (out_valid !== mv[LAT-1] || (mv[LAT-1] && {a_out, b_out, c_out, d_out} !== md[LAT-1]))
                $display("FAIL vector cyc%0d: valid=%0b data=%h, want valid=%0b data=%h",
                         j, out_valid, {a_out, b_out, c_out, d_out}, mv[LAT-1], md[LAT-1]);
            else passes++;
            cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        logic [31:0]  mi, mip;
        for (int i = 0; i < 1000 + LAT; i++) begin
            if (i < 1000) begin
                orig = {$urandom(), $urandom(), $urandom(), $urandom()};
                mi   = $urandom();
                mip  = $urandom();
                cyc(1'b1, 1'b1, g_fwd(orig[127:96], orig[95:64], orig[63:32], orig[31:0], mi, mip), mi, mip, orig);
            end else begin
                cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
            end
            checks++;
            if (out_valid !== mv[LAT-1] || (mv[LAT-1] && {a_out, b_out, c_out, d_out} !== md[LAT-1]))
                $display("FAIL round_trip cyc%0d: valid=%0b data=%h, want valid=%0b data=%h",
                         i, out_valid, {a_out, b_out, c_out, d_out}, mv[LAT-1], md[LAT-1]);
            else passes++;
        end
    endtask

    task automatic test_stall();
        logic [127:0] orig;
        logic [31:0]  mi, mip;
        int           seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            mi   = $urandom();
            mip  = $urandom();
            cyc(1'b1, 1'b1, g_fwd(orig[127:96], orig[95:64], orig[63:32], orig[31:0], mi, mip), mi, mip, orig);
            if (out_valid) seen++;
        end
        for (int i = 0; i < 3 + LAT + 1; i++) begin
            if (i < 3) cyc(1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, $urandom(), $urandom(), 128'h0);
            else       cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
            if (out_valid && i >= 3) seen++;
            checks++;
            if (out_valid !== mv[LAT-1] || (mv[LAT-1] && {a_out, b_out, c_out, d_out} !== md[LAT-1]))
                $display("FAIL stall cyc%0d: valid=%0b data=%h, want valid=%0b data=%h",
                         i, out_valid, {a_out, b_out, c_out, d_out}, mv[LAT-1], md[LAT-1]);
            else passes++;
        end
        checks++;
        if (seen !== 4) $display("FAIL stall_count: got %0d outputs, want 4", seen);
        else passes++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, $urandom(), $urandom(), 128'h0);
        #2 reset = 1'b1;
        #1;
        clear_model();
        checks++;
        if (out_valid !== 1'b0 || {a_out, b_out, c_out, d_out} !== 128'h0)
            $display("FAIL mid_reset_async: valid=%0b data=%h, want valid=0 data=0", out_valid, {a_out, b_out, c_out, d_out});
        else passes++;
        cyc(1'b1, 1'b1, 128'h0, 32'h5, 32'h3, {32'hFFFFFFF8, 32'h0, 32'h0, 32'hFFFFFFFD});
        cyc(1'b1, 1'b1, 128'h0, 32'h5, 32'h3, {32'hFFFFFFF8, 32'h0, 32'h0, 32'hFFFFFFFD});
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
            checks++;
            if (out_valid !== 1'b0)
                $display("FAIL mid_reset_discard cyc%0d: valid=%0b, want 0", i, out_valid);
            else passes++;
        end
        cyc(1'b1, 1'b1, 128'h0, 32'h5, 32'h3, {32'hFFFFFFF8, 32'h0, 32'h0, 32'hFFFFFFFD});
        for (int j = 1; j <= LAT; j++) begin
            checks++;
            if (out_valid !== mv[LAT-1] || (mv[LAT-1] && {a_out, b_out, c_out, d_out} !== md[LAT-1]))
                $display("FAIL mid_reset_fresh cyc%0d: valid=%0b data=%h, want valid=%0b data=%h",
                         j, out_valid, {a_out, b_out, c_out, d_out}, mv[LAT-1], md[LAT-1]);
            else passes++;
            cyc(1'b0, 1'b1, 128'h0, 32'h0, 32'h0, 128'h0);
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_vectors();
        test_round_trip();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
